// File: rtl/fixpoint_sched.sv
// Iterative settle scheduler: feeds a registered state through an external stage until it
// reaches a fixed point or an iteration limit. Macro FIXPOINT_SCHED_OSC_DETECT_EN adds period-2 oscillation detection.
module fixpoint_sched #(
   parameter int W        = 8,
   parameter int MAX_ITER = 4,
   localparam int CW      = $clog2(MAX_ITER + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic [W-1:0]  start_data,
   input  logic          abort,
   output logic [W-1:0]  eval_out,
   input  logic [W-1:0]  eval_in,
   output logic          done_valid,
   input  logic          done_ready,
   output logic [W-1:0]  done_data,
   output logic [CW-1:0] done_iters,
   output logic          done_unstable,
   output logic          done_osc
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        fsm_q;
   logic [W-1:0]  state_q;
   logic [CW-1:0] cnt_q;
   logic          start_ready_q;
   logic          done_valid_q;
   logic [W-1:0]  done_data_q;
   logic [CW-1:0] done_iters_q;
   logic          done_unstable_q;
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
   logic [W-1:0]  prev_q;
   logic          prev_valid_q;
   logic          done_osc_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q           <= IDLE;
         state_q         <= '0;
         cnt_q           <= '0;
         start_ready_q   <= 1'b1;
         done_valid_q    <= 1'b0;
         done_data_q     <= '0;
         done_iters_q    <= '0;
         done_unstable_q <= 1'b0;
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
         prev_q          <= '0;
         prev_valid_q    <= 1'b0;
         done_osc_q      <= 1'b0;
`endif
      end else begin
         case (fsm_q)
            IDLE: begin
               if (start_valid) begin
                  state_q       <= start_data;
                  cnt_q         <= '0;
                  start_ready_q <= 1'b0;
                  fsm_q         <= RUN;
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
                  prev_valid_q  <= 1'b0;
`endif
               end
            end
            RUN: begin
               // Abort outranks every settle/limit decision taken in the same cycle.
               if (abort) begin
                  start_ready_q <= 1'b1;
                  fsm_q         <= IDLE;
               end else if (eval_in == state_q) begin
                  done_data_q     <= state_q;
                  done_iters_q    <= cnt_q;
                  done_unstable_q <= 1'b0;
                  done_valid_q    <= 1'b1;
                  fsm_q           <= DONE;
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
                  done_osc_q      <= 1'b0;
               end else if (prev_valid_q && (eval_in == prev_q)) begin
                  done_data_q     <= state_q;
                  done_iters_q    <= cnt_q;
                  done_unstable_q <= 1'b1;
                  done_osc_q      <= 1'b1;
                  done_valid_q    <= 1'b1;
                  fsm_q           <= DONE;
`endif
               end else if (cnt_q == CW'(MAX_ITER)) begin
                  done_data_q     <= state_q;
                  done_iters_q    <= CW'(MAX_ITER);
                  done_unstable_q <= 1'b1;
                  done_valid_q    <= 1'b1;
                  fsm_q           <= DONE;
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
                  done_osc_q      <= 1'b0;
`endif
               end else begin
                  state_q <= eval_in;
                  cnt_q   <= cnt_q + 1'b1;
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
                  prev_q       <= state_q;
                  prev_valid_q <= 1'b1;
`endif
               end
            end
            DONE: begin
               if (abort || done_ready) begin
                  done_valid_q  <= 1'b0;
                  start_ready_q <= 1'b1;
                  fsm_q         <= IDLE;
               end
            end
            default: begin
               done_valid_q  <= 1'b0;
               start_ready_q <= 1'b1;
               fsm_q         <= IDLE;
            end
         endcase
      end
   end

   assign start_ready   = start_ready_q;
   assign eval_out      = state_q;
   assign done_valid    = done_valid_q;
   assign done_data     = done_data_q;
   assign done_iters    = done_iters_q;
   assign done_unstable = done_unstable_q;
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
   assign done_osc      = done_osc_q;
`else
   assign done_osc      = 1'b0;
`endif

endmodule

// File: tb/tb_fixpoint_sched.sv
// Self-checking bench for fixpoint_sched: a selectable evaluation stage, a reference
// iteration model feeding a scoreboard queue, and handshake/abort/reset scenarios.
module tb_fixpoint_sched;
   localparam int W  = 8;
   localparam int MI = 8;
   localparam int CW = $clog2(MI + 1);
`ifdef FIXPOINT_SCHED_OSC_DETECT_EN
   localparam bit OSC = 1'b1;
`else
   localparam bit OSC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [W-1:0]  start_data = '0;
   logic          abort = 1'b0;
   logic [W-1:0]  eval_out;
   logic [W-1:0]  eval_in;
   logic          done_valid;
   logic          done_ready = 1'b0;
   logic [W-1:0]  done_data;
   logic [CW-1:0] done_iters;
   logic          done_unstable;
   logic          done_osc;

   int tests = 0;
   int fails = 0;
   int fsel  = 0;

   typedef struct {
      logic [W-1:0]  data;
      logic [CW-1:0] iters;
      logic          unst;
      logic          osc;
   } exp_t;
   exp_t sb_q[$];

   fixpoint_sched #(.W(W), .MAX_ITER(MI)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready), .start_data(start_data),
      .abort(abort),
      .eval_out(eval_out), .eval_in(eval_in),
      .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
      .done_iters(done_iters), .done_unstable(done_unstable), .done_osc(done_osc)
   );

   always #5 clk = ~clk;

   // 0 identity, 1 halve, 2 invert, 3 smear right, 4 increment, 5 clear lowest set bit, 6 rotate-xor
   function automatic logic [W-1:0] f_eval(input int fs, input logic [W-1:0] x);
      case (fs)
         0: return x;
         1: return x >> 1;
         2: return ~x;
         3: return x | (x >> 1);
         4: return x + 8'd1;
         5: return x & (x - 8'd1);
         default: return {x[6:0], x[7]} ^ 8'h01;
      endcase
   endfunction

   always_comb eval_in = f_eval(fsel, eval_out);

   function automatic exp_t model(input int fs, input logic [W-1:0] s0);
      exp_t r;
      logic [W-1:0] s, prev, nx;
      bit pv, fin;
      s = s0; prev = '0; pv = 0; fin = 0;
      r.data = '0; r.iters = '0; r.unst = 0; r.osc = 0;
      for (int n = 0; n <= MI && !fin; n++) begin
         nx = f_eval(fs, s);
         if (nx == s) begin
            r.data = s; r.iters = CW'(n); fin = 1;
         end else if (OSC && pv && nx == prev) begin
            r.data = s; r.iters = CW'(n); r.unst = 1; r.osc = 1; fin = 1;
         end else if (n == MI) begin
            r.data = s; r.iters = CW'(MI); r.unst = 1; fin = 1;
         end else begin
            prev = s; pv = 1; s = nx;
         end
      end
      return r;
   endfunction

   task automatic run_job(input string name, input int fs, input logic [W-1:0] s, input int hold);
      exp_t e;
      int lat;
      logic [W-1:0] d0;
      logic [CW-1:0] i0;
      logic u0, o0;
      bit rdy_bad;
      @(negedge clk);
      fsel = fs; start_data = s; start_valid = 1'b1;
      tests++;
      if (start_ready !== 1'b1) begin
         fails++; $display("FAIL %s start_ready got %b want 1", name, start_ready);
      end
      sb_q.push_back(model(fs, s));
      @(negedge clk);
      start_valid = 1'b0;
      lat = 1;
      tests++;
      if (eval_out !== s) begin
         fails++; $display("FAIL %s eval_out_load got %h want %h", name, eval_out, s);
      end
      rdy_bad = 0;
      while (done_valid !== 1'b1 && lat < 40) begin
         if (start_ready !== 1'b0) rdy_bad = 1;
         @(negedge clk);
         lat++;
      end
      tests++;
      if (rdy_bad) begin
         fails++; $display("FAIL %s start_ready_busy got 1 want 0", name);
      end
      e = sb_q.pop_front();
      tests++;
      if (done_valid !== 1'b1) begin
         fails++; $display("FAIL %s timeout done_valid got %b want 1", name, done_valid);
         return;
      end
      $display("[TB] %s start=%h data=%h iters=%0d unst=%b osc=%b lat=%0d", name, s, done_data, done_iters, done_unstable, done_osc, lat);
      tests++;
      if (lat != int'(e.iters) + 2) begin
         fails++; $display("FAIL %s latency got %0d want %0d", name, lat, int'(e.iters) + 2);
      end
      tests++;
      if (done_data !== e.data) begin
         fails++; $display("FAIL %s done_data got %h want %h", name, done_data, e.data);
      end
      tests++;
      if (done_iters !== e.iters) begin
         fails++; $display("FAIL %s done_iters got %0d want %0d", name, done_iters, e.iters);
      end
      tests++;
      if (done_unstable !== e.unst) begin
         fails++; $display("FAIL %s done_unstable got %b want %b", name, done_unstable, e.unst);
      end
      tests++;
      if (done_osc !== e.osc) begin
         fails++; $display("FAIL %s done_osc got %b want %b", name, done_osc, e.osc);
      end
      d0 = done_data; i0 = done_iters; u0 = done_unstable; o0 = done_osc;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         tests++;
         if (done_valid !== 1'b1 || start_ready !== 1'b0 || done_data !== d0 ||
             done_iters !== i0 || done_unstable !== u0 || done_osc !== o0) begin
            fails++;
            $display("FAIL %s hold%0d got v=%b sr=%b d=%h i=%0d want v=1 sr=0 d=%h i=%0d",
                     name, h, done_valid, start_ready, done_data, done_iters, d0, i0);
         end
      end
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
         fails++; $display("FAIL %s release got sr=%b v=%b want sr=1 v=0", name, start_ready, done_valid);
      end
   endtask

   task automatic test_reset();
      tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0 || eval_out !== '0 || done_data !== '0 ||
          done_iters !== '0 || done_unstable !== 1'b0 || done_osc !== 1'b0) begin
         fails++; $display("FAIL reset got sr=%b v=%b eo=%h d=%h i=%0d want sr=1 all else 0",
                           start_ready, done_valid, eval_out, done_data, done_iters);
      end
      $display("[TB] reset sr=%b v=%b eo=%h", start_ready, done_valid, eval_out);
   endtask

   task automatic test_functions();
      run_job("identity", 0, 8'hA5, 0);
      run_job("halving", 1, 8'h10, 0);
      run_job("inverter", 2, 8'h0F, 0);
      run_job("limit_inc", 4, 8'h00, 0);
      run_job("settle_at_limit", 5, 8'hFF, 0);
      for (int k = 0; k < 4; k++) run_job("random_smear", 3, W'($urandom_range(0, 255)), 0);
      for (int k = 0; k < 4; k++) run_job("random_rotx", 6, W'($urandom_range(0, 255)), 0);
   endtask

   task automatic test_back_to_back();
      run_job("backpressure", 1, 8'h80, 5);
      run_job("b2b_a", 5, 8'h0F, 0);
      run_job("b2b_b", 0, 8'h3C, 2);
   endtask

   task automatic test_abort();
      bit seen;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (start_ready !== 1'b1) begin
         fails++; $display("FAIL abort_idle start_ready got %b want 1", start_ready);
      end
      fsel = 4; start_data = 8'h20; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
         fails++; $display("FAIL abort_run got sr=%b v=%b want sr=1 v=0", start_ready, done_valid);
      end
      seen = 0;
      for (int c = 0; c < MI + 4; c++) begin
         @(negedge clk);
         if (done_valid !== 1'b0) seen = 1;
      end
      tests++;
      if (seen) begin
         fails++; $display("FAIL abort_no_result got done_valid=1 want 0");
      end
      fsel = 0; start_data = 8'h5A; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (done_valid !== 1'b1) begin
         fails++; $display("FAIL abort_done_setup done_valid got %b want 1", done_valid);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0) begin
         fails++; $display("FAIL abort_done got sr=%b v=%b want sr=1 v=0", start_ready, done_valid);
      end
      $display("[TB] abort scenarios sr=%b v=%b", start_ready, done_valid);
   endtask

   task automatic test_reset_mid_run();
      fsel = 4; start_data = 8'h40; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (start_ready !== 1'b1 || done_valid !== 1'b0 || eval_out !== '0 || done_data !== '0 ||
          done_iters !== '0 || done_unstable !== 1'b0 || done_osc !== 1'b0) begin
         fails++; $display("FAIL reset_mid got sr=%b v=%b eo=%h d=%h i=%0d want sr=1 all else 0",
                           start_ready, done_valid, eval_out, done_data, done_iters);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset mid-run sr=%b eo=%h", start_ready, eval_out);
      run_job("after_reset", 1, 8'h04, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_functions();
      test_back_to_back();
      test_abort();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
